// File: rtl/ecc_ff_pkg.sv
// Shared constants, FSM state type and the divide-by-x helper for the GF(2^163) inverter.
// Optional build macro: ECC_FF_INV_CYCLE_CNT_EN (step counter port on ecc_ff_inv).
package ecc_ff_pkg;

    localparam int unsigned M     = 163;
    localparam int unsigned DEG_W = $clog2(M + 1);
    localparam int unsigned CNT_W = 10;

    localparam logic [M-1:0] F_LOW  = {{(M-8){1'b0}}, 8'hC9};
    localparam logic [M:0]   F_POLY = {1'b1, F_LOW};
    localparam logic [M:0]   U_ONE  = {{M{1'b0}}, 1'b1};
    localparam logic [M-1:0] G_ONE  = {{(M-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // g * x^-1 mod f: an odd g first absorbs f (bit M set, bit 0 cancels), then shifts.
    function automatic logic [M-1:0] div_x(input logic [M-1:0] g);
        logic [M-1:0] t;
        t = g[0] ? (g ^ F_LOW) : g;
        return {g[0], t[M-1:1]};
    endfunction

endpackage

// File: rtl/ecc_ff_deg.sv
// Leading-one detector: returns the index of the highest set bit of an (M+1)-bit value (0 for 0).
module ecc_ff_deg
    import ecc_ff_pkg::*;
(
    input  logic [M:0]       i_x,
    output logic [DEG_W-1:0] o_deg
);

    always_comb begin
        o_deg = '0;
        for (int unsigned i = 0; i <= M; i++) begin
            if (i_x[i]) begin
                o_deg = DEG_W'(i);
            end
        end
    end

endmodule

// File: rtl/ecc_ff_inv.sv
// GF(2^163) multiplicative inverter via binary extended Euclid, one step per clock.
// Optional build macro: ECC_FF_INV_CYCLE_CNT_EN adds the cyc_cnt step-count output.
module ecc_ff_inv
    import ecc_ff_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M-1:0]     a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M-1:0]     q,
    output logic             err
`ifdef ECC_FF_INV_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt
`endif
);

    state_t           r_state;
    state_t           w_next_state;
    logic [M:0]       r_u;
    logic [M:0]       r_v;
    logic [M-1:0]     r_g1;
    logic [M-1:0]     r_g2;
    logic [M-1:0]     r_q;
    logic             r_err;
    logic [DEG_W-1:0] w_deg_u;
    logic [DEG_W-1:0] w_deg_v;
    logic             w_accept;
    logic             w_u_one;
    logic             w_v_one;
    logic             w_finish;

    ecc_ff_deg u_deg_u (
        .i_x   (r_u),
        .o_deg (w_deg_u)
    );

    ecc_ff_deg u_deg_v (
        .i_x   (r_v),
        .o_deg (w_deg_v)
    );

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_u_one  = (r_u == U_ONE);
    assign w_v_one  = (r_v == U_ONE);
    assign w_finish = (r_state == RUN) && (w_u_one || w_v_one);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = (a == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_u_one || w_v_one) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        q         = r_q;
        err       = r_err;
    end

    // Datapath: the termination tests take priority over any reduction step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_u   <= '0;
            r_v   <= '0;
            r_g1  <= '0;
            r_g2  <= '0;
            r_q   <= '0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_q <= '0;
            if (a == '0) begin
                r_err <= 1'b1;
            end else begin
                r_u   <= {1'b0, a};
                r_v   <= F_POLY;
                r_g1  <= G_ONE;
                r_g2  <= '0;
                r_err <= 1'b0;
            end
        end else if (r_state == RUN) begin
            if (w_u_one) begin
                r_q <= r_g1;
            end else if (w_v_one) begin
                r_q <= r_g2;
            end else if (!r_u[0]) begin
                r_u  <= r_u >> 1;
                r_g1 <= div_x(r_g1);
            end else if (!r_v[0]) begin
                r_v  <= r_v >> 1;
                r_g2 <= div_x(r_g2);
            end else if (w_deg_u >= w_deg_v) begin
                r_u  <= r_u ^ r_v;
                r_g1 <= r_g1 ^ r_g2;
            end else begin
                r_v  <= r_v ^ r_u;
                r_g2 <= r_g2 ^ r_g1;
            end
        end
    end

`ifdef ECC_FF_INV_CYCLE_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // The terminating RUN cycle is not a reduction step, so it is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if ((r_state == RUN) && !w_finish) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cyc_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_ecc_ff_inv.sv
// Directed and randomised self-checking bench for ecc_ff_inv (honours ECC_FF_INV_CYCLE_CNT_EN).
module tb_ecc_ff_inv;

    localparam int           TM      = 163;
    localparam logic [162:0] TF_LOW  = 163'hC9;
    localparam int           LAT_MAX = 4 * TM + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [TM-1:0]  a_i = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [TM-1:0]  q_o;
    logic           err_o;
`ifdef ECC_FF_INV_CYCLE_CNT_EN
    logic [9:0]     cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    ecc_ff_inv u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q_o),
        .err       (err_o)
`ifdef ECC_FF_INV_CYCLE_CNT_EN
        ,
        .cyc_cnt   (cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Reference GF(2^163) multiply: MSB-first shift-and-add with reduction by x^163 = x^7+x^6+x^3+1.
    function automatic logic [TM-1:0] gf_mul(input logic [TM-1:0] x, input logic [TM-1:0] y);
        logic [TM-1:0] r;
        r = '0;
        for (int i = TM - 1; i >= 0; i--) begin
            r = r[TM-1] ? ((r << 1) ^ TF_LOW) : (r << 1);
            if (y[i]) r = r ^ x;
        end
        return r;
    endfunction

    task automatic do_op(input logic [TM-1:0] av, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        in_valid = 1'b1;
        a_i      = av;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < LAT_MAX + 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++; if (q_o !== '0)         begin n_fail++; $display("FAIL reset_q got %h want 0", q_o); end
        n_tests++; if (err_o !== 1'b0)     begin n_fail++; $display("FAIL reset_err got %b want 0", err_o); end
`ifdef ECC_FF_INV_CYCLE_CNT_EN
        n_tests++; if (cnt_o !== 10'd0)    begin n_fail++; $display("FAIL reset_cnt got %0d want 0", cnt_o); end
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_one();
        int lat;
        do_op(163'd1, lat);
        n_tests++; if (lat !== 1)          begin n_fail++; $display("FAIL one_latency got %0d want 1", lat); end
        n_tests++; if (q_o !== 163'd1)     begin n_fail++; $display("FAIL one_q got %h want 1", q_o); end
        n_tests++; if (err_o !== 1'b0)     begin n_fail++; $display("FAIL one_err got %b want 0", err_o); end
`ifdef ECC_FF_INV_CYCLE_CNT_EN
        n_tests++; if (cnt_o !== 10'd0)    begin n_fail++; $display("FAIL one_cnt got %0d want 0", cnt_o); end
`endif
        release_result();
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL one_release got ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_x();
        int lat;
        logic [TM-1:0] exp_q;
        exp_q = '0;
        exp_q[162] = 1'b1; exp_q[6] = 1'b1; exp_q[5] = 1'b1; exp_q[2] = 1'b1;
        do_op(163'd2, lat);
        n_tests++; if (lat !== 2)          begin n_fail++; $display("FAIL x_latency got %0d want 2", lat); end
        n_tests++; if (q_o !== exp_q)      begin n_fail++; $display("FAIL x_q got %h want %h", q_o, exp_q); end
        n_tests++; if (err_o !== 1'b0)     begin n_fail++; $display("FAIL x_err got %b want 0", err_o); end
`ifdef ECC_FF_INV_CYCLE_CNT_EN
        n_tests++; if (cnt_o !== 10'd1)    begin n_fail++; $display("FAIL x_cnt got %0d want 1", cnt_o); end
`endif
        release_result();
    endtask

    task automatic test_zero();
        int lat;
        do_op(163'd0, lat);
        n_tests++; if (lat !== 0)          begin n_fail++; $display("FAIL zero_latency got %0d want 0", lat); end
        n_tests++; if (q_o !== '0)         begin n_fail++; $display("FAIL zero_q got %h want 0", q_o); end
        n_tests++; if (err_o !== 1'b1)     begin n_fail++; $display("FAIL zero_err got %b want 1", err_o); end
`ifdef ECC_FF_INV_CYCLE_CNT_EN
        n_tests++; if (cnt_o !== 10'd0)    begin n_fail++; $display("FAIL zero_cnt got %0d want 0", cnt_o); end
`endif
        release_result();
    endtask

    task automatic test_hold();
        int lat;
        logic [TM-1:0] q0;
        do_op(163'd3, lat);
        q0 = q_o;
        n_tests++; if (gf_mul(163'd3, q_o) !== 163'd1) begin n_fail++; $display("FAIL hold_inv3 got %h want product 1", q_o); end
        for (int c = 0; c < 20; c++) begin
            in_valid = c[0];
            a_i      = 163'd5;
            @(posedge clk); #1;
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid c=%0d got %b want 1", c, out_valid); end
            n_tests++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL hold_ready c=%0d got %b want 0", c, in_ready); end
            n_tests++; if (q_o !== q0)         begin n_fail++; $display("FAIL hold_q c=%0d got %h want %h", c, q_o, q0); end
            n_tests++; if (err_o !== 1'b0)     begin n_fail++; $display("FAIL hold_err c=%0d got %b want 0", c, err_o); end
        end
        in_valid = 1'b0;
        release_result();
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_release got ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
        in_valid = 1'b1;
        a_i      = 163'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_accept5 got ready=%b valid=%b want 0/0", in_ready, out_valid);
        end
        lat = 0;
        while (!out_valid && lat < LAT_MAX + 10) begin
            @(posedge clk); #1;
            lat++;
        end
        n_tests++; if (lat > LAT_MAX)                   begin n_fail++; $display("FAIL hold5_latency got %0d want <= %0d", lat, LAT_MAX); end
        n_tests++; if (gf_mul(163'd5, q_o) !== 163'd1) begin n_fail++; $display("FAIL hold5_inv got %h want product 1", q_o); end
        release_result();
    endtask

    task automatic test_reset_mid_run();
        int seen;
        in_valid = 1'b1;
        a_i      = 163'h1234;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrun_busy got ready=%b valid=%b want 0/0", in_ready, out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL midrun_rst_ready got %b want 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_valid got %b want 0", out_valid); end
        n_tests++; if (q_o !== '0)         begin n_fail++; $display("FAIL midrun_rst_q got %h want 0", q_o); end
        n_tests++; if (err_o !== 1'b0)     begin n_fail++; $display("FAIL midrun_rst_err got %b want 0", err_o); end
`ifdef ECC_FF_INV_CYCLE_CNT_EN
        n_tests++; if (cnt_o !== 10'd0)    begin n_fail++; $display("FAIL midrun_rst_cnt got %0d want 0", cnt_o); end
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 700; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
        end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL midrun_spurious got %0d bad cycles want 0", seen); end
    endtask

    task automatic test_random();
        int lat;
        logic [191:0]  raw;
        logic [TM-1:0] av;
        for (int k = 0; k < 40; k++) begin
            raw = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            av  = raw[TM-1:0];
            if (av == '0) av = 163'd1;
            do_op(av, lat);
            n_tests++; if (lat > LAT_MAX) begin n_fail++; $display("FAIL rnd_latency k=%0d got %0d want <= %0d", k, lat, LAT_MAX); end
            n_tests++; if (gf_mul(av, q_o) !== 163'd1 || err_o !== 1'b0) begin
                n_fail++; $display("FAIL rnd_inv k=%0d a=%h q=%h err=%b want product 1 err 0", k, av, q_o, err_o);
            end
`ifdef ECC_FF_INV_CYCLE_CNT_EN
            n_tests++; if (int'(cnt_o) !== lat - 1) begin n_fail++; $display("FAIL rnd_cnt k=%0d got %0d want %0d", k, cnt_o, lat - 1); end
`endif
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            release_result();
        end
    endtask

    initial begin
        test_reset();
        test_one();
        test_x();
        test_zero();
        test_hold();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
